alu_control_fsm: RTL

- Multicycle control unit for the 16-bit processor. It drives the arithmetic_logic_system control interface (ALUop, ALUsrc) and consumes its AltB flag.
- Sequences fetch/decode/execute/memory/writeback for each instruction and handshakes with memory via mem_ready.
- Sits between the instruction register and the datapath. It is the producer side of the ALU control interface.

---
 rtl/proc16_pkg.sv | 46 ++++
 rtl/alu_ctrl_decode.sv | 49 ++++
 rtl/alu_control_fsm.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/proc16_pkg.sv
// Shared types and encodings for the 16-bit processor control path:
// FSM states, ALU operation codes, opcodes, PC source selects and instruction classes.
package proc16_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_LW,
        CLS_SW,
        CLS_BLT,
        CLS_J,
        CLS_ILL
    } instr_class_e;

    localparam logic [2:0] ALU_AND = 3'd0;
    localparam logic [2:0] ALU_OR  = 3'd1;
    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_SHF = 3'd4;
    localparam logic [2:0] ALU_SLT = 3'd5;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_SHF  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_SHFI = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_BLT  = 4'hA;
    localparam logic [3:0] OP_J    = 4'hB;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational opcode decoder: yields the ALU operation, operand-B select and
// instruction class; shared by the EXEC, MEM and WB states of alu_control_fsm.
module alu_ctrl_decode
    import proc16_pkg::*;
(
    input  logic [3:0]   opcode,
    output logic [2:0]   alu_op,
    output logic         alu_src,
    output instr_class_e op_class
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        alu_op   = ALU_AND;
        alu_src  = 1'b0;
        op_class = CLS_ILL;
        case (opcode)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SHF, OP_SLT: begin
                alu_op   = opcode[2:0];
                alu_src  = 1'b1;
                op_class = CLS_ALU;
            end
            OP_ADDI: begin
                alu_op   = ALU_ADD;
                op_class = CLS_ALU;
            end
            OP_SHFI: begin
                alu_op   = ALU_SHF;
                op_class = CLS_ALU;
            end
            OP_LW: begin
                alu_op   = ALU_ADD;
                op_class = CLS_LW;
            end
            OP_SW: begin
                alu_op   = ALU_ADD;
                op_class = CLS_SW;
            end
            OP_BLT: begin
                alu_op   = ALU_SLT;
                alu_src  = 1'b1;
                op_class = CLS_BLT;
            end
            OP_J:    op_class = CLS_J;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_control_fsm.sv
// Multicycle control unit for the 16-bit processor (FETCH/DECODE/EXEC/MEM/WB).
// Optional ILLEGAL_TRAP_EN: illegal opcodes trap (sticky flag, jump) instead of retiring as NOP.
module alu_control_fsm
    import proc16_pkg::*;
#(
    parameter int OP_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  opcode,
    input  logic             AltB,
    input  logic             mem_ready,
    output logic [2:0]       ALUop,
    output logic             ALUsrc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRwrite,
    output logic             PCwrite,
    output logic [1:0]       PCsrc,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             busy,
    output logic [CNT_W-1:0] retired,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             illegal_q, illegal_d;
    logic             retire;
    logic             trap;

    logic [2:0]       dec_alu_op;
    logic             dec_alu_src;
    instr_class_e     op_class;

    alu_ctrl_decode u_decode (
        .opcode   (opcode[OP_W-1 -: 4]),
        .alu_op   (dec_alu_op),
        .alu_src  (dec_alu_src),
        .op_class (op_class)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        trap    = 1'b0;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: state_d = EXEC;
            EXEC: begin
                case (op_class)
                    CLS_ALU:        state_d = WB;
                    CLS_LW, CLS_SW: state_d = MEM;
                    CLS_ILL: begin
                        state_d = FETCH;
`ifdef ILLEGAL_TRAP_EN
                        trap    = 1'b1;
`else
                        retire  = 1'b1;
`endif
                    end
                    default: begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end
                endcase
            end
            MEM: begin
                if (mem_ready) begin
                    if (op_class == CLS_LW) begin
                        state_d = WB;
                    end else begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end
                end
            end
            WB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        retired_d = retired_q + CNT_W'(retire);
        illegal_d = illegal_q | trap;
    end

    // Reset forces every control strobe low even though the state already reads FETCH.
    always_comb begin
        ALUop    = ALU_AND;
        ALUsrc   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRwrite  = 1'b0;
        PCwrite  = 1'b0;
        PCsrc    = PC_INC;
        RegWrite = 1'b0;
        MemtoReg = 1'b0;
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    IRwrite = mem_ready;
                    PCwrite = mem_ready;
                end
                EXEC: begin
                    ALUop  = dec_alu_op;
                    ALUsrc = dec_alu_src;
                    case (op_class)
                        CLS_BLT: begin
                            if (AltB) begin
                                PCwrite = 1'b1;
                                PCsrc   = PC_BRANCH;
                            end
                        end
                        CLS_J: begin
                            PCwrite = 1'b1;
                            PCsrc   = PC_JUMP;
                        end
`ifdef ILLEGAL_TRAP_EN
                        CLS_ILL: begin
                            PCwrite = 1'b1;
                            PCsrc   = PC_JUMP;
                        end
`endif
                        default: ;
                    endcase
                end
                MEM: begin
                    ALUop    = dec_alu_op;
                    ALUsrc   = dec_alu_src;
                    MemRead  = (op_class == CLS_LW);
                    MemWrite = (op_class == CLS_SW);
                end
                WB: begin
                    ALUop    = dec_alu_op;
                    ALUsrc   = dec_alu_src;
                    RegWrite = 1'b1;
                    MemtoReg = (op_class == CLS_LW);
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_q != FETCH);
    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule
